// File: rtl/aes_prng_reseed_ctrl.sv
// PRNG reseed scheduler (step-count or software trigger) plus a one-word EDN entropy buffer.
// Latency: the reseed request rises 1 cycle after its trigger, and the PRNG ack follows the EDN ack by 1 cycle.
// Backpressure: the request holds until reseed_req is acked; one buffered word; optional timeout (AES_PRNG_RESEED_TIMEOUT_EN).
module aes_prng_reseed_ctrl #(
    parameter int unsigned EntropyWidth  = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              rate_i,
    input  logic                    step_i,
    input  logic                    sw_reseed_i,
    output logic                    reseed_req_o,
    input  logic                    reseed_ack_i,
    input  logic                    prng_ent_req_i,
    output logic                    prng_ent_ack_o,
    output logic [EntropyWidth-1:0] prng_ent_o,
    output logic                    edn_req_o,
    input  logic                    edn_ack_i,
    input  logic [EntropyWidth-1:0] edn_data_i,
    output logic                    busy_o,
    output logic                    timeout_err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [13:0]       step_cnt_q;
    logic [13:0]       step_cnt_inc;
    logic [13:0]       thresh;
    logic              thresh_hit;
    logic [EntropyWidth-1:0] buf_q;
    logic              buf_valid_q;

    always_comb begin
        thresh = 14'd8192;
        case (rate_i)
            2'd0:    thresh = 14'd64;
            2'd1:    thresh = 14'd256;
            default: thresh = 14'd8192;
        endcase
    end

    // Compare against the post-increment count so the request rises right after the triggering step.
    assign step_cnt_inc = (step_i && (step_cnt_q != 14'h3FFF)) ? step_cnt_q + 14'd1 : step_cnt_q;
    assign thresh_hit   = (rate_i != 2'd3) && (step_cnt_inc >= thresh);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sw_reseed_i || thresh_hit) state_d = REQ;
            REQ:     if (reseed_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_cnt_q <= 14'd0;
        end else if (state_q == IDLE) begin
            step_cnt_q <= step_cnt_inc;
        end else if (reseed_ack_i) begin
            step_cnt_q <= 14'd0;
        end
    end

    assign reseed_req_o = (state_q == REQ);
    assign busy_o       = (state_q == REQ);

    // Capture and delivery are mutually exclusive because both depend on buf_valid_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
        end else if (!buf_valid_q && edn_ack_i) begin
            buf_q       <= edn_data_i;
            buf_valid_q <= 1'b1;
        end else if (prng_ent_ack_o) begin
            buf_valid_q <= 1'b0;
        end
    end

    // The request is gated by reset so that every output reads 0 while reset is held.
    assign edn_req_o      = prng_ent_req_i & ~buf_valid_q & rst_ni;
    assign prng_ent_ack_o = prng_ent_req_i & buf_valid_q;
    assign prng_ent_o     = buf_q;

`ifdef AES_PRNG_RESEED_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

    logic [15:0] to_cnt_q;
    logic        to_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= 16'd0;
            to_err_q <= 1'b0;
        end else if (state_q == REQ) begin
            if (to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
            if (to_cnt_q == TimeoutLast) to_err_q <= 1'b1;
        end else begin
            to_cnt_q <= 16'd0;
        end
    end

    assign timeout_err_o = to_err_q;
`else
    logic [15:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 16'(TimeoutCycles);
    assign timeout_err_o         = 1'b0;
`endif

endmodule
